// File: rtl/vec_mem_seq_pkg.sv
// Shared constants and types for the CVP14 vector load/store sequencer.
package cvp14_pkg;

    localparam logic [3:0] VLD = 4'b0100;
    localparam logic [3:0] VST = 4'b0101;

    localparam int VLEN    = 16;
    localparam int DW      = 16;
    localparam int VREG_W  = VLEN * DW;
    localparam int VRIDX_W = 3;
    localparam int AW      = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        WB
    } vseq_state_e;

endpackage

// File: rtl/vec_mem_seq_if.sv
// Data-memory port between the vector sequencer (master) and the arbiter/memory (slave).
interface vec_mem_seq_if
    import cvp14_pkg::*;
#(
    parameter int DW = cvp14_pkg::DW
);

    logic [AW-1:0] mem_addr;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_gnt;

    modport master (
        output mem_addr,
        output mem_rd,
        output mem_wr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_gnt
    );

    modport slave (
        input  mem_addr,
        input  mem_rd,
        input  mem_wr,
        input  mem_wdata,
        output mem_rdata,
        output mem_gnt
    );

endinterface

// File: rtl/vec_mem_seq_rd_lat_pipe.sv
// Valid-bit delay line marking the cycle in which an accepted read returns its data.
module rd_lat_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic vld_i,
    output logic vld_o
);

    logic [RD_LAT-1:0] sr_q;
    logic [RD_LAT-1:0] sr_d;

    generate
        if (RD_LAT == 1) begin : g_one
            assign sr_d = vld_i;
        end else begin : g_multi
            assign sr_d = {sr_q[RD_LAT-2:0], vld_i};
        end
    endgenerate

    // Reset flushes every in-flight marker so late data is never captured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vld_o = sr_q[RD_LAT-1];

endmodule

// File: rtl/vec_mem_seq.sv
// Moves one vector register between the register file and memory, one element per granted cycle.
module vec_mem_seq
    import cvp14_pkg::*;
#(
    parameter int VLEN   = cvp14_pkg::VLEN,
    parameter int DW     = cvp14_pkg::DW,
    parameter int RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               is_store,
    input  logic [AW-1:0]      base_addr,
    input  logic [VRIDX_W-1:0] vreg_idx,
    input  logic [VLEN*DW-1:0] vst_data,
    output logic               busy,
    output logic               done,
    vec_mem_seq_if.master      mem,
    output logic               vrf_wr_en,
    output logic [VRIDX_W-1:0] vrf_wr_dst,
    output logic [VLEN*DW-1:0] vrf_wr_data
);

    localparam int IW = $clog2(VLEN);
    localparam int CW = IW + 1;

    typedef logic [VLEN-1:0][DW-1:0] vec_t;

    vseq_state_e        state_q, state_d;
    logic               is_store_q;
    logic [AW-1:0]      base_q;
    logic [VRIDX_W-1:0] vreg_q;
    vec_t               vec_q, vec_d;
    logic [CW-1:0]      icnt_q, icnt_d;
    logic [CW-1:0]      ccnt_q, ccnt_d;
    logic               done_q, done_d;

    logic issue;
    logic start_acc;
    logic rd_acc;
    logic rd_ret;

    assign issue     = (state_q == ISSUE);
    assign busy      = (state_q != IDLE) | done_q;
    assign start_acc = (state_q == IDLE) & start & ~busy;
    assign rd_acc    = issue & ~is_store_q & mem.mem_gnt;

    rd_lat_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_lat (
        .clk   (clk),
        .rst_n (rst_n),
        .vld_i (rd_acc),
        .vld_o (rd_ret)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            icnt_q  <= '0;
            ccnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            ccnt_q  <= ccnt_d;
            done_q  <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            base_q     <= '0;
            vreg_q     <= '0;
            vec_q      <= '0;
        end else begin
            vec_q <= vec_d;
            if (start_acc) begin
                is_store_q <= is_store;
                base_q     <= base_addr;
                vreg_q     <= vreg_idx;
            end
        end
    end

    // One buffer serves both directions: store source on VST, assembly target on VLD.
    always_comb begin
        vec_d  = vec_q;
        ccnt_d = ccnt_q;
        if (start_acc) begin
            vec_d  = vec_t'(vst_data);
            ccnt_d = '0;
        end else if (rd_ret) begin
            vec_d[ccnt_q[IW-1:0]] = mem.mem_rdata;
            ccnt_d                = ccnt_q + CW'(1);
        end
    end

    // DRAIN looks at ccnt_d so WB follows the final capture without a dead cycle.
    always_comb begin
        state_d = state_q;
        icnt_d  = icnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_acc) begin
                    state_d = ISSUE;
                    icnt_d  = '0;
                end
            end
            ISSUE: begin
                if (mem.mem_gnt) begin
                    icnt_d = icnt_q + CW'(1);
                    if (icnt_q == CW'(VLEN - 1)) begin
                        if (is_store_q) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (ccnt_d == CW'(VLEN)) begin
                    state_d = WB;
                end
            end
            WB: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        mem.mem_rd    = issue & ~is_store_q;
        mem.mem_wr    = issue & is_store_q;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (issue) begin
            mem.mem_addr  = base_q + AW'(icnt_q);
            mem.mem_wdata = vec_q[icnt_q[IW-1:0]];
        end
    end

    assign vrf_wr_en   = (state_q == WB);
    assign vrf_wr_dst  = vrf_wr_en ? vreg_q : '0;
    assign vrf_wr_data = vrf_wr_en ? vec_q : '0;
    assign done        = vrf_wr_en | done_q;

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: one instance at read latency 1, one at read latency 3.
module tb_vec_mem_seq;
    import cvp14_pkg::*;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         start     = 1'b0;
    logic         is_store  = 1'b0;
    logic         gnt       = 1'b1;
    logic [15:0]  base_addr = '0;
    logic [2:0]   vreg_idx  = '0;
    logic [255:0] vst_data  = '0;

    logic         busy1, done1, en1, busy3, done3, en3;
    logic [2:0]   dst1, dst3;
    logic [255:0] data1, data3;
    logic [15:0]  a1_q;
    logic [15:0]  a3_q [3];

    int checks   = 0;
    int failures = 0;

    vec_mem_seq_if m1 ();
    vec_mem_seq_if m3 ();

    always #5 clk = ~clk;

    vec_mem_seq #(.RD_LAT(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .base_addr(base_addr), .vreg_idx(vreg_idx), .vst_data(vst_data),
        .busy(busy1), .done(done1), .mem(m1),
        .vrf_wr_en(en1), .vrf_wr_dst(dst1), .vrf_wr_data(data1)
    );

    vec_mem_seq #(.RD_LAT(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start), .is_store(is_store),
        .base_addr(base_addr), .vreg_idx(vreg_idx), .vst_data(vst_data),
        .busy(busy3), .done(done3), .mem(m3),
        .vrf_wr_en(en3), .vrf_wr_dst(dst3), .vrf_wr_data(data3)
    );

    // Memory: a read of address A returns A ^ 0xA5A5 after the instance's latency.
    assign m1.mem_gnt   = gnt;
    assign m3.mem_gnt   = gnt;
    assign m1.mem_rdata = a1_q ^ 16'hA5A5;
    assign m3.mem_rdata = a3_q[2] ^ 16'hA5A5;

    always @(posedge clk) begin
        a1_q    <= m1.mem_addr;
        a3_q[0] <= m3.mem_addr;
        a3_q[1] <= a3_q[0];
        a3_q[2] <= a3_q[1];
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] ld_vec(input logic [15:0] base);
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = (base + 16'(i)) ^ 16'hA5A5;
        return v;
    endfunction

    function automatic logic [255:0] st_vec();
        logic [255:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'h1110 + 16'(i);
        return v;
    endfunction

    task automatic chk_zero(input string tn);
        chk({tn, "_busy1"},  256'(busy1),        256'(0));
        chk({tn, "_done1"},  256'(done1),        256'(0));
        chk({tn, "_rd1"},    256'(m1.mem_rd),    256'(0));
        chk({tn, "_wr1"},    256'(m1.mem_wr),    256'(0));
        chk({tn, "_addr1"},  256'(m1.mem_addr),  256'(0));
        chk({tn, "_wdata1"}, 256'(m1.mem_wdata), 256'(0));
        chk({tn, "_en1"},    256'(en1),          256'(0));
        chk({tn, "_dst1"},   256'(dst1),         256'(0));
        chk({tn, "_data1"},  data1,              256'(0));
        chk({tn, "_busy3"},  256'(busy3),        256'(0));
        chk({tn, "_done3"},  256'(done3),        256'(0));
        chk({tn, "_rd3"},    256'(m3.mem_rd),    256'(0));
        chk({tn, "_addr3"},  256'(m3.mem_addr),  256'(0));
        chk({tn, "_en3"},    256'(en3),          256'(0));
        chk({tn, "_data3"},  data3,              256'(0));
    endtask

    // Start sampled at edge 0; cycle c is the period ending at edge c, sampled on its negedge.
    task automatic run_vld(input logic [15:0] base, input logic [2:0] vreg, input string tn);
        logic [15:0] ea;
        start = 1'b1; is_store = 1'b0; base_addr = base; vreg_idx = vreg;
        vst_data = ~ld_vec(base);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= 22; c++) begin
            ea = base + 16'(c - 1);
            chk($sformatf("%s_rd1_c%0d", tn, c), 256'(m1.mem_rd), 256'(c <= 16));
            chk($sformatf("%s_wr1_c%0d", tn, c), 256'(m1.mem_wr), 256'(0));
            chk($sformatf("%s_rd3_c%0d", tn, c), 256'(m3.mem_rd), 256'(c <= 16));
            if (c <= 16) begin
                chk($sformatf("%s_addr1_c%0d", tn, c), 256'(m1.mem_addr), 256'(ea));
                chk($sformatf("%s_addr3_c%0d", tn, c), 256'(m3.mem_addr), 256'(ea));
            end
            chk($sformatf("%s_done1_c%0d", tn, c), 256'(done1), 256'(c == 18));
            chk($sformatf("%s_en1_c%0d", tn, c),   256'(en1),   256'(c == 18));
            chk($sformatf("%s_busy1_c%0d", tn, c), 256'(busy1), 256'(c <= 18));
            chk($sformatf("%s_done3_c%0d", tn, c), 256'(done3), 256'(c == 20));
            chk($sformatf("%s_en3_c%0d", tn, c),   256'(en3),   256'(c == 20));
            chk($sformatf("%s_busy3_c%0d", tn, c), 256'(busy3), 256'(c <= 20));
            if (c == 18) begin
                chk({tn, "_dst1"},  256'(dst1), 256'(vreg));
                chk({tn, "_data1"}, data1,      ld_vec(base));
            end
            if (c == 20) begin
                chk({tn, "_dst3"},  256'(dst3), 256'(vreg));
                chk({tn, "_data3"}, data3,      ld_vec(base));
            end
            @(negedge clk);
        end
    endtask

    task automatic run_vst(input logic [15:0] base, input bit stall, input bit ign,
                           input int exp_done, input string tn);
        int e, nd1, nd3, dc1, dc3;
        start = 1'b1; is_store = 1'b1; base_addr = base; vreg_idx = 3'd1;
        vst_data = st_vec();
        @(posedge clk);
        @(negedge clk);
        e = 0; nd1 = 0; nd3 = 0; dc1 = 0; dc3 = 0;
        for (int c = 1; c <= 24; c++) begin
            gnt = !(stall && c >= 5 && c <= 7);
            if (ign && (c == 5 || c == exp_done)) begin
                start = 1'b1; is_store = 1'b0; base_addr = 16'h0100; vreg_idx = 3'd7;
            end else begin
                start = 1'b0;
            end
            chk($sformatf("%s_wr1_c%0d", tn, c), 256'(m1.mem_wr), 256'(e < 16));
            chk($sformatf("%s_wr3_c%0d", tn, c), 256'(m3.mem_wr), 256'(e < 16));
            chk($sformatf("%s_rd1_c%0d", tn, c), 256'(m1.mem_rd), 256'(0));
            chk($sformatf("%s_rd3_c%0d", tn, c), 256'(m3.mem_rd), 256'(0));
            if (e < 16) begin
                chk($sformatf("%s_addr1_c%0d", tn, c),  256'(m1.mem_addr),  256'(base + 16'(e)));
                chk($sformatf("%s_wdata1_c%0d", tn, c), 256'(m1.mem_wdata), 256'(16'h1110 + 16'(e)));
            end
            chk($sformatf("%s_en1_c%0d", tn, c),   256'(en1),   256'(0));
            chk($sformatf("%s_en3_c%0d", tn, c),   256'(en3),   256'(0));
            chk($sformatf("%s_busy1_c%0d", tn, c), 256'(busy1), 256'(c <= exp_done));
            chk($sformatf("%s_busy3_c%0d", tn, c), 256'(busy3), 256'(c <= exp_done));
            if (done1) begin nd1++; dc1 = c; end
            if (done3) begin nd3++; dc3 = c; end
            if (gnt && e < 16) e++;
            @(negedge clk);
        end
        gnt = 1'b1; start = 1'b0;
        chk({tn, "_ndone1"}, 256'(nd1), 256'(1));
        chk({tn, "_dcyc1"},  256'(dc1), 256'(exp_done));
        chk({tn, "_ndone3"}, 256'(nd3), 256'(1));
        chk({tn, "_dcyc3"},  256'(dc3), 256'(exp_done));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 chk_zero("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);

        run_vld(16'h0100, 3'd3, "vld");
        run_vst(16'h2000, 1'b0, 1'b0, 17, "vst");
        run_vld(16'hFFF8, 3'd5, "wrap");
        run_vst(16'h2000, 1'b1, 1'b0, 20, "stall");
        run_vst(16'h3000, 1'b0, 1'b1, 17, "ign");

        // Reset in cycle 9 of a load, then a fresh load must run cleanly.
        start = 1'b1; is_store = 1'b0; base_addr = 16'h0100; vreg_idx = 3'd2; vst_data = '0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 9; c++) @(negedge clk);
        rst_n = 1'b0;
        #1 chk_zero("rst_mid");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("post_rst_done1_%0d", c), 256'(done1), 256'(0));
            chk($sformatf("post_rst_en1_%0d", c),   256'(en1),   256'(0));
            chk($sformatf("post_rst_done3_%0d", c), 256'(done3), 256'(0));
            chk($sformatf("post_rst_en3_%0d", c),   256'(en3),   256'(0));
            chk($sformatf("post_rst_busy3_%0d", c), 256'(busy3), 256'(0));
            @(negedge clk);
        end
        run_vld(16'h0040, 3'd6, "fresh");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
